// File: rtl/multi_channel_interval_timer_if.sv
// Register bus for the multi-channel interval timer: word address, chip select,
// active-low write strobe, 32-bit write data and registered read data.
interface multi_channel_interval_timer_if #(
    parameter int NUM_CH = 4
) ();
    localparam int ADDR_W = $clog2(NUM_CH) + 3;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/multi_channel_interval_timer.sv
// NUM_CH independent down-counting interval timers behind a word-addressed register bus.
// The per-channel prescaler exists only when TIMER_PRESCALE_EN is defined.
module multi_channel_interval_timer #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h0007_A11F
) (
    input  logic                          clk,
    input  logic                          reset,
    multi_channel_interval_timer_if.slave bus,
    output logic [NUM_CH-1:0]             irq_vec,
    output logic                          irq
);
    localparam int ADDR_W = $clog2(NUM_CH) + 3;

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_CONTROL  = 3'd1;
    localparam logic [2:0] OFF_PERIOD   = 3'd2;
    localparam logic [2:0] OFF_SNAP     = 3'd3;
`ifdef TIMER_PRESCALE_EN
    localparam logic [2:0] OFF_PRESCALE = 3'd4;
`endif

    logic [ADDR_W-1:0]         w_ch_sel;
    logic [2:0]                w_off;
    logic                      w_wr;
    logic [NUM_CH-1:0][31:0]   w_rd_ch;
    logic [31:0]               w_rd_mux;
    logic [31:0]               r_readdata;

    assign w_ch_sel = bus.address >> 3;
    assign w_off    = bus.address[2:0];
    assign w_wr     = bus.chipselect && !bus.write_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_period;
            logic [CNT_W-1:0] r_snap;
            logic [3:0]       r_ctrl;
            logic             r_run;
            logic             r_to;
            logic             w_sel;
            logic             w_tick;
            logic             w_timeout;
            logic [31:0]      w_rd;

            assign w_sel     = w_wr && (w_ch_sel == ADDR_W'(gi));
            assign w_timeout = w_tick && r_run && (r_cnt == '0);

`ifdef TIMER_PRESCALE_EN
            logic [15:0] r_pre;
            logic [15:0] r_pre_cnt;

            // >= rather than == so a PRESCALE lowered mid-count ticks at once instead of wrapping.
            assign w_tick = (r_pre_cnt >= r_pre);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pre     <= '0;
                    r_pre_cnt <= '0;
                end else begin
                    if (r_run) begin
                        r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
                    end
                    if (w_sel && (w_off == OFF_PRESCALE)) begin
                        r_pre <= bus.writedata[15:0];
                    end
                    if (w_sel && ((w_off == OFF_PERIOD) ||
                                  ((w_off == OFF_CONTROL) && bus.writedata[2]))) begin
                        r_pre_cnt <= '0;
                    end
                end
            end
`else
            assign w_tick = 1'b1;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt    <= RESET_PERIOD[CNT_W-1:0];
                    r_period <= RESET_PERIOD[CNT_W-1:0];
                    r_snap   <= '0;
                    r_ctrl   <= '0;
                    r_run    <= 1'b0;
                    r_to     <= 1'b0;
                end else begin
                    if (w_tick && r_run) begin
                        if (r_cnt == '0) begin
                            r_to  <= 1'b1;
                            r_cnt <= r_period;
                            if (!r_ctrl[1]) begin
                                r_run <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    // Register writes land after the count update so they override it,
                    // except that a same-edge timeout keeps TO set.
                    if (w_sel) begin
                        case (w_off)
                            OFF_STATUS: begin
                                if (!w_timeout) begin
                                    r_to <= 1'b0;
                                end
                            end
                            OFF_CONTROL: begin
                                r_ctrl <= bus.writedata[3:0];
                                if (bus.writedata[2]) begin
                                    r_run <= 1'b1;
                                end else if (bus.writedata[3]) begin
                                    r_run <= 1'b0;
                                end
                            end
                            OFF_PERIOD: begin
                                r_period <= bus.writedata[CNT_W-1:0];
                                r_cnt    <= bus.writedata[CNT_W-1:0];
                                r_run    <= 1'b0;
                            end
                            OFF_SNAP: begin
                                r_snap <= r_cnt;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            always_comb begin
                w_rd = '0;
                case (w_off)
                    OFF_STATUS:   w_rd = {30'd0, r_run, r_to};
                    OFF_CONTROL:  w_rd = {28'd0, r_ctrl};
                    OFF_PERIOD:   w_rd = 32'(r_period);
                    OFF_SNAP:     w_rd = 32'(r_snap);
`ifdef TIMER_PRESCALE_EN
                    OFF_PRESCALE: w_rd = {16'd0, r_pre};
`endif
                    default:      w_rd = '0;
                endcase
            end

            assign w_rd_ch[gi] = w_rd;
            assign irq_vec[gi] = r_to && r_ctrl[0];
        end
    endgenerate

    // Channel numbers beyond NUM_CH match no entry and read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_sel == ADDR_W'(i)) begin
                w_rd_mux = w_rd_ch[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |irq_vec;
endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed bench for multi_channel_interval_timer: a register vector table followed by
// cycle-exact sequences for counting, one-shot irq, prescale, priority and reset.
module tb_multi_channel_interval_timer;
    localparam int          NUM_CH = 4;
    localparam logic [31:0] RST_P  = 32'h0007_A11F;

    localparam int OFF_STATUS   = 0;
    localparam int OFF_CONTROL  = 1;
    localparam int OFF_PERIOD   = 2;
    localparam int OFF_SNAP     = 3;
    localparam int OFF_PRESCALE = 4;

`ifdef TIMER_PRESCALE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    typedef struct {
        bit          is_wr;
        int          ch;
        int          off;
        logic [31:0] data;
        string       name;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;
    int                n_tests = 0;
    int                n_fail  = 0;
    vec_t              tbl[22];

    multi_channel_interval_timer_if #(.NUM_CH(NUM_CH)) bus ();

    multi_channel_interval_timer #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (32),
        .RESET_PERIOD(RST_P)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irq_vec(irq_vec),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input bit w, input int ch, input int off,
                                input logic [31:0] d, input string nm);
        vec_t v;
        v.is_wr = w;
        v.ch    = ch;
        v.off   = off;
        v.data  = d;
        v.name  = nm;
        return v;
    endfunction

    function automatic logic [4:0] addr(input int ch, input int off);
        return 5'((ch << 3) | off);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Both tasks are entered at a negedge and return at the next one.
    task automatic wr(input int ch, input int off, input logic [31:0] d);
        bus.address    = addr(ch, off);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int off, output logic [31:0] d);
        bus.address    = addr(ch, off);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        d              = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          seq0[6] = '{4, 3, 2, 1, 0, 4};
        int          t_to;

        tbl[0]  = mk(0, 0, OFF_STATUS,   32'h0,        "rst ch0 status");
        tbl[1]  = mk(0, 0, OFF_CONTROL,  32'h0,        "rst ch0 control");
        tbl[2]  = mk(0, 0, OFF_PERIOD,   RST_P,        "rst ch0 period");
        tbl[3]  = mk(0, 3, OFF_PERIOD,   RST_P,        "rst ch3 period");
        tbl[4]  = mk(0, 2, OFF_SNAP,     32'h0,        "rst ch2 snap");
        tbl[5]  = mk(0, 1, OFF_PRESCALE, 32'h0,        "rst ch1 prescale");
        tbl[6]  = mk(1, 1, OFF_CONTROL,  32'hF3,       "");
        tbl[7]  = mk(0, 1, OFF_CONTROL,  32'h3,        "ch1 control low nibble");
        tbl[8]  = mk(0, 1, OFF_STATUS,   32'h0,        "ch1 status no start");
        tbl[9]  = mk(1, 1, OFF_PRESCALE, 32'h12345,    "");
        tbl[10] = mk(0, 1, OFF_PRESCALE, PRE_EN ? 32'h2345 : 32'h0, "ch1 prescale 16b");
        tbl[11] = mk(1, 1, 5,            32'hFFFF,     "");
        tbl[12] = mk(0, 1, 5,            32'h0,        "ch1 off5 reads 0");
        tbl[13] = mk(0, 1, 7,            32'h0,        "ch1 off7 reads 0");
        tbl[14] = mk(1, 2, OFF_PERIOD,   32'hABCD,     "");
        tbl[15] = mk(0, 2, OFF_PERIOD,   32'hABCD,     "ch2 period rw");
        tbl[16] = mk(0, 1, OFF_PERIOD,   RST_P,        "ch1 period untouched");
        tbl[17] = mk(1, 1, OFF_CONTROL,  32'h0,        "");
        tbl[18] = mk(1, 1, OFF_PRESCALE, 32'h0,        "");
        tbl[19] = mk(0, 1, OFF_PRESCALE, 32'h0,        "ch1 prescale cleared");
        tbl[20] = mk(1, 3, OFF_STATUS,   32'hFFFF_FFFF, "");
        tbl[21] = mk(0, 3, OFF_STATUS,   32'h0,        "ch3 status write no set");

        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst irq_vec", 32'(irq_vec), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst readdata", bus.readdata, 32'h0);

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].ch, tbl[i].off, tbl[i].data);
            end else begin
                rd(tbl[i].ch, tbl[i].off, got);
                chk(tbl[i].name, got, tbl[i].data);
            end
        end

        // ch0 continuous, period 4: held SNAP writes show the counter two cycles late.
        wr(0, OFF_PERIOD, 32'd4);
        wr(0, OFF_CONTROL, 32'h6);
        bus.address    = addr(0, OFF_SNAP);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = '0;
        for (int m = 1; m <= 7; m++) begin
            @(negedge clk);
            if (m >= 2) chk($sformatf("ch0 count seq %0d", m - 2), bus.readdata, 32'(seq0[m-2]));
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        rd(0, OFF_STATUS, got);
        chk("ch0 TO set RUN kept", got, 32'h3);
        wr(0, OFF_STATUS, 32'h0);
        rd(0, OFF_STATUS, got);
        chk("ch0 TO cleared", got, 32'h2);
        rd(0, OFF_STATUS, got);
        chk("ch0 TO after 5 clocks", got, 32'h3);
        wr(0, OFF_STATUS, 32'h0);
        repeat (2) @(negedge clk);
        wr(0, OFF_STATUS, 32'h0);
        rd(0, OFF_STATUS, got);
        chk("ch0 timeout beats status write", got, 32'h3);
        wr(0, OFF_CONTROL, 32'h8);
        rd(0, OFF_STATUS, got);
        chk("ch0 stop clears run", 32'(got[1]), 32'h0);
        wr(0, OFF_CONTROL, 32'hC);
        rd(0, OFF_STATUS, got);
        chk("ch0 start wins over stop", 32'(got[1]), 32'h1);
        rd(0, OFF_CONTROL, got);
        chk("ch0 control 0xC", got, 32'hC);
        wr(0, OFF_CONTROL, 32'h8);
        wr(0, OFF_STATUS, 32'h0);

        // ch1 one-shot with interrupt enabled.
        wr(1, OFF_PERIOD, 32'd3);
        wr(1, OFF_CONTROL, 32'h5);
        for (int m = 1; m <= 4; m++) begin
            @(negedge clk);
            chk($sformatf("ch1 irq_vec cycle %0d", m), 32'(irq_vec), (m == 4) ? 32'h2 : 32'h0);
            chk($sformatf("ch1 irq cycle %0d", m), 32'(irq), (m == 4) ? 32'h1 : 32'h0);
        end
        rd(1, OFF_STATUS, got);
        chk("ch1 one-shot TO no RUN", got, 32'h1);
        wr(1, OFF_SNAP, 32'h0);
        rd(1, OFF_SNAP, got);
        chk("ch1 counter reloaded", got, 32'h3);
        wr(1, OFF_STATUS, 32'h0);
        chk("ch1 irq_vec after clear", 32'(irq_vec), 32'h0);
        chk("ch1 irq after clear", 32'(irq), 32'h0);

        // ch2 prescaled one-shot.
        wr(2, OFF_PRESCALE, 32'd2);
        wr(2, OFF_PERIOD, 32'd1);
        wr(2, OFF_CONTROL, 32'h4);
        t_to = PRE_EN ? 6 : 2;
        for (int m = 0; m < 8; m++) begin
            rd(2, OFF_STATUS, got);
            chk($sformatf("ch2 status clk %0d", m), got, (m >= t_to) ? 32'h1 : 32'h2);
        end
        rd(2, OFF_PRESCALE, got);
        chk("ch2 prescale readback", got, PRE_EN ? 32'h2 : 32'h0);

        // ch3: PERIOD write while running, then SNAP capture of the pre-edge counter.
        wr(3, OFF_PERIOD, 32'h10);
        wr(3, OFF_CONTROL, 32'h6);
        wr(3, OFF_PERIOD, 32'h55);
        rd(3, OFF_STATUS, got);
        chk("ch3 period write stops", got, 32'h0);
        wr(3, OFF_SNAP, 32'h0);
        rd(3, OFF_SNAP, got);
        chk("ch3 counter loaded", got, 32'h55);
        wr(3, OFF_CONTROL, 32'h6);
        wr(3, OFF_SNAP, 32'h0);
        rd(3, OFF_SNAP, got);
        chk("ch3 snap pre-edge", got, 32'h55);
        wr(3, OFF_SNAP, 32'h0);
        rd(3, OFF_SNAP, got);
        chk("ch3 snap after 2 ticks", got, 32'h53);
        wr(3, OFF_CONTROL, 32'h8);
        rd(0, OFF_PERIOD, got);
        chk("ch0 period kept", got, 32'h4);
        rd(1, OFF_PERIOD, got);
        chk("ch1 period kept", got, 32'h3);
        rd(1, OFF_CONTROL, got);
        chk("ch1 control kept", got, 32'h5);
        rd(2, OFF_PERIOD, got);
        chk("ch2 period kept", got, 32'h1);

        // Every channel timing out each clock, then one reset cycle.
        for (int c = 0; c < NUM_CH; c++) begin
            wr(c, OFF_PERIOD, 32'h0);
            wr(c, OFF_CONTROL, 32'h7);
        end
        repeat (4) @(negedge clk);
        chk("pre-reset irq_vec", 32'(irq_vec), 32'hF);
        bus.address = addr(0, OFF_CONTROL);
        @(negedge clk);
        chk("pre-reset readdata", bus.readdata, 32'h7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset irq_vec", 32'(irq_vec), 32'h0);
        chk("mid reset irq", 32'(irq), 32'h0);
        chk("mid reset readdata", bus.readdata, 32'h0);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int o = 0; o <= OFF_PRESCALE; o++) begin
                rd(c, o, got);
                chk($sformatf("post-reset ch%0d off%0d", c, o), got,
                    (o == OFF_PERIOD) ? RST_P : 32'h0);
            end
            wr(c, OFF_SNAP, 32'h0);
            rd(c, OFF_SNAP, got);
            chk($sformatf("post-reset ch%0d counter", c), got, RST_P);
        end
        chk("post-reset irq", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_channel_interval_timer.md
MULTI_CHANNEL_INTERVAL_TIMER -- requirements
Module: multi_channel_interval_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width (8..32); register bits above CNT_W read 0 and are ignored on write.
REQ-003 SHALL have parameter RESET_PERIOD, default 32'h0007_A11F, reset value of every channel's period.
REQ-004 SHALL have port clk, input, 1, sole clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port address, input, $clog2(NUM_CH)+3, word address; [2:0] register select, upper bits channel select.
REQ-007 SHALL have ports chipselect (input, 1, access qualifier) and write_n (input, 1, active-low write).
REQ-008 SHALL have ports writedata (input, 32) and readdata (output, 32, registered read data).
REQ-009 SHALL have port irq_vec, output, NUM_CH, per-channel interrupt.
REQ-010 SHALL have port irq, output, 1, OR of irq_vec.

Function
REQ-011 SHALL map registers per channel: 0 STATUS (bit0 TO, bit1 RUN; any write clears TO), 1 CONTROL (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP; bits 3:0 stored), 2 PERIOD, 3 SNAP (write captures counter, read returns capture), 4 PRESCALE (16 bits); offsets 5-7 and channels >= NUM_CH read 0, writes ignored.
REQ-012 SHALL return readdata one cycle after the chipselect cycle; readdata updates every cycle from the current address.
REQ-013 SHALL generate per-channel tick: every clock when PRESCALE=0, else once per PRESCALE+1 clocks while RUN=1.
REQ-014 SHALL, on a tick with RUN=1 and counter!=0, decrement the counter by 1.
REQ-015 SHALL, on a tick with RUN=1 and counter==0, set TO, reload counter from PERIOD, and clear RUN if CONT=0; timeout interval is (PERIOD+1)*(PRESCALE+1) clocks.
REQ-016 SHALL, on a PERIOD write, update PERIOD, load counter with writedata[CNT_W-1:0], clear RUN and the prescaler count at the same edge.
REQ-017 SHALL, on a CONTROL write with START=1, set RUN and clear the prescaler count; START and STOP both set -> RUN=1 (start wins).
REQ-018 SHALL, on a CONTROL write with STOP=1 and START=0, clear RUN; counter holds its value.
REQ-019 SHALL give the timeout priority over a same-cycle STATUS write: TO ends the cycle at 1.
REQ-020 SHALL drive irq_vec[n] = TO[n] & ITO[n], combinationally from registered state.
REQ-021 SHALL keep channels fully independent; accessing one channel never alters another.
REQ-022 SHALL capture on a SNAP write the counter value present before that edge's decrement.

Reset
REQ-023 SHALL, with reset high at a clk edge, set per channel: counter=PERIOD=RESET_PERIOD, RUN=0, TO=0, CONTROL=0, PRESCALE=0, SNAP=0, prescaler count=0; readdata=0, irq_vec=0, irq=0.
REQ-024 SHALL let reset mid-count abandon all state with no timeout or irq generated for that cycle.

Configuration
REQ-025 SHALL compile the prescaler in only when macro TIMER_PRESCALE_EN is defined; with it REQ-013 applies as stated.
REQ-026 SHALL, without TIMER_PRESCALE_EN, omit prescaler logic: tick=1 every clock, PRESCALE reads 0, writes ignored.

Verification
REQ-027 SHALL verify: ch0 PERIOD=4, CONTROL=0x6 (START|CONT) -> TO every 5 clocks, RUN stays 1, counter sequence 4,3,2,1,0,4.
REQ-028 SHALL verify: ch1 PERIOD=3, CONTROL=0x5 (START|ITO, one-shot) -> irq_vec[1] and irq rise after 4 ticks, RUN=0, counter reloaded to 3; STATUS write -> irq low next cycle.
REQ-029 SHALL verify (TIMER_PRESCALE_EN): ch2 PRESCALE=2, PERIOD=1, START -> TO after 6 clocks; same test without macro -> TO after 2 clocks and PRESCALE reads 0.
REQ-030 SHALL verify: STATUS write in same cycle as ch0 timeout -> TO=1; CONTROL=0xC -> RUN=1.
REQ-031 SHALL verify: PERIOD write while running with counter=0x10 -> RUN=0, counter=new value; SNAP write then read offset 3 -> returns pre-edge counter, other channels unchanged.
REQ-032 SHALL verify: reset asserted one cycle mid-count on all channels -> all registers at REQ-023 values, irq=0, PERIOD reads RESET_PERIOD masked to CNT_W.
